// File: rtl/dtree_vote_accum.sv
// Majority-vote smoother behind the decision-tree classifier: counts class votes over a
// window of legal predictions and hands the winning class downstream over valid/ready.
module dtree_vote_accum #(
    parameter int unsigned NUM_CLASSES = 3,
    parameter int unsigned WINDOW      = 8,
    localparam int unsigned CNT_W      = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_class,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_class,
    output logic [CNT_W-1:0] out_count,
    output logic             out_tie,
    output logic             err
);

    localparam logic [1:0] ACCUM  = 2'd0;
    localparam logic [1:0] DECIDE = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(WINDOW);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] votes_q [4];
    logic [CNT_W-1:0] votes_d [4];
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [1:0]       out_class_q, out_class_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_tie_q, out_tie_d;
    logic             err_q, err_d;

    logic             window_full;
    logic             legal;
    logic [1:0]       best_class;
    logic [CNT_W-1:0] best_count;
    logic             best_tie;

    // A full window parks in ACCUM for one cycle with in_ready low before DECIDE.
    assign window_full = (sample_cnt_q == WIN_CNT);
    assign legal       = ({30'd0, in_class} < NUM_CLASSES);
    assign in_ready    = (state_q == ACCUM) && !window_full;
    assign out_valid   = (state_q == HOLD);
    assign out_class   = out_class_q;
    assign out_count   = out_count_q;
    assign out_tie     = out_tie_q;
    assign err         = err_q;

    // Strict '>' keeps the lowest index on ties; a later strictly larger count clears the tie.
    always_comb begin
        best_class = 2'd0;
        best_count = votes_q[0];
        best_tie   = 1'b0;
        for (int unsigned i = 1; i < NUM_CLASSES; i++) begin
            if (votes_q[2'(i)] > best_count) begin
                best_class = 2'(i);
                best_count = votes_q[2'(i)];
                best_tie   = 1'b0;
            end else if (votes_q[2'(i)] == best_count) begin
                best_tie = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        votes_d      = votes_q;
        sample_cnt_d = sample_cnt_q;
        out_class_d  = out_class_q;
        out_count_d  = out_count_q;
        out_tie_d    = out_tie_q;
        err_d        = err_q;
        if (clear) begin
            state_d      = ACCUM;
            for (int i = 0; i < 4; i++) votes_d[i] = '0;
            sample_cnt_d = '0;
            out_class_d  = 2'd0;
            out_count_d  = '0;
            out_tie_d    = 1'b0;
            err_d        = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (window_full) begin
                        state_d = DECIDE;
                    end else if (in_valid) begin
                        if (legal) begin
                            votes_d[in_class] = votes_q[in_class] + ONE;
                            sample_cnt_d      = sample_cnt_q + ONE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                DECIDE: begin
                    out_class_d = best_class;
                    out_count_d = best_count;
                    out_tie_d   = best_tie;
                    state_d     = HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        for (int i = 0; i < 4; i++) votes_d[i] = '0;
                        sample_cnt_d = '0;
                        state_d      = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACCUM;
            for (int i = 0; i < 4; i++) votes_q[i] <= '0;
            sample_cnt_q <= '0;
            out_class_q  <= 2'd0;
            out_count_q  <= '0;
            out_tie_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            votes_q      <= votes_d;
            sample_cnt_q <= sample_cnt_d;
            out_class_q  <= out_class_d;
            out_count_q  <= out_count_d;
            out_tie_q    <= out_tie_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_dtree_vote_accum.sv
// Directed and randomized checks of dtree_vote_accum against a vote-tally reference model.
module tb_dtree_vote_accum;

    localparam int NC    = 3;
    localparam int WIN   = 8;
    localparam int CNT_W = $clog2(WIN + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_class = 2'd0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [1:0]       out_class;
    logic [CNT_W-1:0] out_count;
    logic             out_tie;
    logic             err;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: plain per-class tallies and a sticky error bit.
    int mvotes[4];
    int mcnt = 0;
    bit merr = 0;
    int last_class = 0, last_count = 0, last_tie = 0;

    dtree_vote_accum #(.NUM_CLASSES(NC), .WINDOW(WIN)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
        .out_count(out_count), .out_tie(out_tie), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed running, expected done");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear_window();
        for (int i = 0; i < 4; i++) mvotes[i] = 0;
        mcnt = 0;
    endtask

    task automatic model_expect(output int cls, output int cnt, output int tie);
        int maxv = -1;
        int nmax = 0;
        cls = 0;
        for (int i = 0; i < NC; i++) if (mvotes[i] > maxv) begin maxv = mvotes[i]; cls = i; end
        for (int i = 0; i < NC; i++) if (mvotes[i] == maxv) nmax++;
        cnt = maxv;
        tie = (nmax > 1) ? 1 : 0;
    endtask

    // Present one sample and wait (bounded) until it is accepted.
    task automatic feed(input logic [1:0] c);
        int n = 0;
        in_valid = 1'b1;
        in_class = c;
        while (!in_ready && n < 50) begin step(); n++; end
        chk("feed_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        if (int'(c) < NC) begin mvotes[c]++; mcnt++; end
        else merr = 1;
        in_valid = 1'b0;
    endtask

    // Called right after the edge that accepted the last legal sample of a window.
    task automatic expect_decision(input string tag, input int hold_cycles);
        int cls, cnt, tie;
        model_expect(cls, cnt, tie);
        out_ready = 1'b0;
        in_valid  = 1'($urandom_range(0, 1));
        in_class  = 2'($urandom_range(0, 2));
        chk({tag, "_t0_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_t0_in_ready"}, {31'd0, in_ready}, 32'd0);
        step();
        chk({tag, "_t1_valid"}, {31'd0, out_valid}, 32'd0);
        step();
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_class"}, {30'd0, out_class}, 32'(cls));
        chk({tag, "_count"}, 32'(out_count), 32'(cnt));
        chk({tag, "_tie"}, {31'd0, out_tie}, 32'(tie));
        chk({tag, "_err"}, {31'd0, err}, 32'(merr));
        for (int k = 0; k < hold_cycles; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_class = 2'($urandom_range(0, 3));
            step();
            chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_hold_class"}, {30'd0, out_class}, 32'(cls));
            chk({tag, "_hold_count"}, 32'(out_count), 32'(cnt));
            chk({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk({tag, "_after_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_after_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_after_class"}, {30'd0, out_class}, 32'(cls));
        last_class = cls; last_count = cnt; last_tie = tie;
        model_clear_window();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_class"}, {30'd0, out_class}, 32'd0);
        chk({tag, "_count"}, 32'(out_count), 32'd0);
        chk({tag, "_tie"}, {31'd0, out_tie}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        logic [1:0] seq_b [8];
        logic [1:0] c;
        model_clear_window();

        // Reset state
        #12;
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        step();
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Eight samples of class 2
        for (int i = 0; i < WIN; i++) feed(2'd2);
        expect_decision("all2", 0);

        // Clear majority
        seq_b = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd0, 2'd1, 2'd2};
        for (int i = 0; i < WIN; i++) feed(seq_b[i]);
        expect_decision("maj1", 0);

        // Tie between 0 and 2
        for (int i = 0; i < WIN; i++) feed((i % 2 == 0) ? 2'd0 : 2'd2);
        expect_decision("tie02", 0);

        // Backpressure, then a fresh window needs WIN new samples
        for (int i = 0; i < WIN; i++) feed(2'($urandom_range(0, 2)));
        expect_decision("bp", 5);
        for (int i = 0; i < WIN - 1; i++) feed(2'd1);
        repeat (3) begin
            step();
            chk("bp_partial_valid", {31'd0, out_valid}, 32'd0);
        end
        feed(2'd0);
        expect_decision("bp_fresh", 0);

        // Illegal code after three legal samples
        feed(2'd0); feed(2'd2); feed(2'd2);
        feed(2'd3);
        chk("illegal_err", {31'd0, err}, 32'd1);
        for (int i = 0; i < WIN - 4; i++) feed(2'd1);
        step();
        chk("illegal_no_early_valid", {31'd0, out_valid}, 32'd0);
        chk("illegal_in_ready", {31'd0, in_ready}, 32'd1);
        feed(2'd2);
        expect_decision("illegal", 0);
        chk("illegal_err_sticky", {31'd0, err}, 32'd1);

        // Clear mid-window, with a sample presented on the clear edge
        feed(2'd1); feed(2'd1); feed(2'd1);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_class = 2'd1;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        merr = 0;
        model_clear_window();
        chk_outputs_zero("clear");
        for (int i = 0; i < WIN; i++) feed((i < 3) ? 2'd2 : 2'd0);
        expect_decision("post_clear", 0);

        // Asynchronous reset mid-clock after 5 samples
        feed(2'd3);
        for (int i = 0; i < 5; i++) feed(2'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("async_rst");
        #2;
        rst_n = 1'b1;
        merr = 0;
        model_clear_window();
        step();
        for (int i = 0; i < WIN - 1; i++) feed(2'd2);
        repeat (3) begin
            step();
            chk("rst_partial_valid", {31'd0, out_valid}, 32'd0);
        end
        feed(2'd1);
        expect_decision("post_rst", 0);

        // Randomized windows with occasional illegal codes and stalls
        for (int w = 0; w < 8; w++) begin
            while (mcnt < WIN) begin
                c = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                if ($urandom_range(0, 3) == 0) step();
                feed(c);
            end
            expect_decision("rand", $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
